// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls words from a synchronous FIFO and sends each one as a UART frame.
// Frame layout: start bit, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stop bits.
// The line idles high. Two extra high cycles (POP, LOAD) separate back-to-back frames.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rd_en_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    // The bit index counts data bits, and is reused to count stop bits.
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_WIDTH-1:0] BAUD_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]     DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]     STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic                 PARITY_INV = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]            state_q,    state_d;
    logic [CNT_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]      bit_idx_q,  bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  parity_q,   parity_d;
    logic                  baud_tick;
    logic                  more_work;

    assign baud_tick = (baud_cnt_q == BAUD_LAST);
    assign more_work = enable_i && !fifo_empty_i;

    // Next-state logic: frame sequencing and bit-period timing.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        case (state_q)
            S_IDLE: begin
                if (more_work) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // The FIFO's registered data is valid one cycle after the pop.
                shift_d    = fifo_rdata_i;
                parity_d   = (^fifo_rdata_i) ^ PARITY_INV;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                state_d    = S_START;
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (!baud_tick) begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end else begin
                    baud_cnt_d = '0;
                    case (state_q)
                        S_START: begin
                            state_d = S_DATA;
                        end
                        S_DATA: begin
                            shift_d = shift_q >> 1;
                            if (bit_idx_q == DATA_LAST) begin
                                bit_idx_d = '0;
                                state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 1'b1;
                            end
                        end
                        S_PARITY: begin
                            state_d = S_STOP;
                        end
                        default: begin
                            // Last stop bit: chain straight into the next pop when work is waiting.
                            if (bit_idx_q == STOP_LAST) begin
                                bit_idx_d = '0;
                                state_d   = more_work ? S_POP : S_IDLE;
                            end else begin
                                bit_idx_d = bit_idx_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; an async reset drops any frame in flight, including a popped word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
        end
    end

    // Line driver is decoded from state, so reset forces the line high without a clock.
    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = shift_q[0];
            S_PARITY: tx_o = parity_q;
            default:  tx_o = 1'b1;
        endcase
    end

    assign fifo_rd_en_o = (state_q == S_POP);
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_STOP) && baud_tick && (bit_idx_q == STOP_LAST);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives three configurations of fifo_uart_tx from behavioural FIFOs
// and compares every cycle against a frame-table reference model and a line decoder.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 10;
    localparam int PAR_EN  [3] = '{0, 1, 1};
    localparam int PAR_ODD [3] = '{0, 0, 1};
    localparam int STOP_B  [3] = '{1, 2, 1};

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] fifoEmpty;
    logic [2:0] rdEnO;
    logic [2:0] txO;
    logic [2:0] busyO;
    logic [2:0] doneO;
    logic [9:0] rdata [3];

    logic [9:0] mem [3][256];
    int         pushCnt [3];
    int         popCnt  [3];

    int          phase     [3];
    logic [15:0] frameBits [3];
    int          nBits     [3];
    logic [9:0]  curWord   [3];
    logic [2:0]  sawRdEn;

    int         cyc;
    logic [2:0] inFrame;
    int         fallCyc  [3];
    int         lastDone [3];
    int         rdCyc    [3];
    logic [9:0] decWord  [3];

    int checkCount;
    int errorCount;
    int snap [3];

    fifo_uart_tx #(.DATA_WIDTH(10), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifoEmpty[0]),
        .fifo_rdata_i(rdata[0]), .fifo_rd_en_o(rdEnO[0]), .tx_o(txO[0]),
        .busy_o(busyO[0]), .frame_done_o(doneO[0]));

    fifo_uart_tx #(.DATA_WIDTH(10), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifoEmpty[1]),
        .fifo_rdata_i(rdata[1]), .fifo_rd_en_o(rdEnO[1]), .tx_o(txO[1]),
        .busy_o(busyO[1]), .frame_done_o(doneO[1]));

    fifo_uart_tx #(.DATA_WIDTH(10), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifoEmpty[2]),
        .fifo_rdata_i(rdata[2]), .fifo_rd_en_o(rdEnO[2]), .tx_o(txO[2]),
        .busy_o(busyO[2]), .frame_done_o(doneO[2]));

    always #5 clk = ~clk;

    // Compares one observed value against the bench's expectation and tallies the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // FIFO empty flag follows the behavioural FIFO occupancy.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            fifoEmpty[k] = (pushCnt[k] == popCnt[k]);
        end
    end

    // FIFO read side plus the reference model: a pop starts a frame whose line pattern is a bit table.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                phase[k] = -1;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (sawRdEn[k]) begin
                    checkOutput($sformatf("rdWhileEmpty[%0d]", k), {31'd0, fifoEmpty[k]}, 32'd0);
                    curWord[k] = mem[k][popCnt[k] & 255];
                    rdata[k]  <= curWord[k];
                    popCnt[k] <= popCnt[k] + 1;
                end
                if (phase[k] == -1) begin
                    if (enable && !fifoEmpty[k]) phase[k] = 0;
                end else if (phase[k] == 0) begin
                    logic [9:0] w;
                    w = mem[k][popCnt[k] & 255];
                    frameBits[k] = 16'hFFFF;
                    frameBits[k][0] = 1'b0;
                    for (int i = 0; i < DW; i++) frameBits[k][i+1] = w[i];
                    if (PAR_EN[k] != 0) frameBits[k][DW+1] = (^w) ^ (PAR_ODD[k] != 0);
                    nBits[k] = 1 + DW + PAR_EN[k] + STOP_B[k];
                    phase[k] = 1;
                end else if (phase[k] >= 2 && (phase[k] - 2) == nBits[k] * CPB - 1) begin
                    phase[k] = (enable && !fifoEmpty[k]) ? 0 : -1;
                end else begin
                    phase[k] = phase[k] + 1;
                end
            end
        end
    end

    // Per-cycle comparison just before the rising edge, plus a mid-bit line decoder.
    always @(negedge clk) begin
        #4;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            logic expTx;
            logic expDone;
            int off;
            int bi;
            expTx   = 1'b1;
            expDone = 1'b0;
            if (phase[k] >= 2) begin
                expTx   = frameBits[k][(phase[k] - 2) / CPB];
                expDone = ((phase[k] - 2) == nBits[k] * CPB - 1);
            end
            checkOutput($sformatf("tx[%0d]", k),    {31'd0, txO[k]},   {31'd0, expTx});
            checkOutput($sformatf("rdEn[%0d]", k),  {31'd0, rdEnO[k]}, {31'd0, (phase[k] == 0)});
            checkOutput($sformatf("busy[%0d]", k),  {31'd0, busyO[k]}, {31'd0, (phase[k] >= 0)});
            checkOutput($sformatf("done[%0d]", k),  {31'd0, doneO[k]}, {31'd0, expDone});
            sawRdEn[k] = rdEnO[k];
            if (rdEnO[k]) rdCyc[k] = cyc;
            if (rst) begin
                inFrame[k] = 1'b0;
            end else if (!inFrame[k]) begin
                if (txO[k] == 1'b0) begin
                    inFrame[k] = 1'b1;
                    fallCyc[k] = cyc;
                    decWord[k] = '0;
                    if (lastDone[k] > 0 && rdCyc[k] == lastDone[k] + 1) begin
                        checkOutput($sformatf("frameGap[%0d]", k), cyc - lastDone[k] - 1, 32'd2);
                    end
                end
            end else begin
                off = cyc - fallCyc[k];
                bi  = off / CPB;
                if (off % CPB == CPB / 2) begin
                    if (bi >= 1 && bi <= DW) decWord[k][bi-1] = txO[k];
                    if (PAR_EN[k] != 0 && bi == DW + 1) begin
                        checkOutput($sformatf("parityBit[%0d]", k), {31'd0, txO[k]},
                                    {31'd0, (^decWord[k]) ^ (PAR_ODD[k] != 0)});
                    end
                end
                if (doneO[k]) begin
                    checkOutput($sformatf("frameLen[%0d]", k), off + 1, (1 + DW + PAR_EN[k] + STOP_B[k]) * CPB);
                    checkOutput($sformatf("word[%0d]", k), {22'd0, decWord[k]}, {22'd0, curWord[k]});
                    lastDone[k] = cyc;
                    inFrame[k]  = 1'b0;
                end
            end
        end
    end

    task automatic pushWord(input int k, input logic [9:0] w);
        mem[k][pushCnt[k] & 255] = w;
        pushCnt[k]++;
    endtask

    task automatic pushAll(input logic [9:0] w);
        for (int k = 0; k < 3; k++) pushWord(k, w);
    endtask

    task automatic applyStimulus(input logic en, input int cycles);
        enable = en;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic takeSnap();
        for (int k = 0; k < 3; k++) snap[k] = popCnt[k];
    endtask

    task automatic checkPops(input string tag, input int expected);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s[%0d]", tag, k), popCnt[k] - snap[k], expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%sTx[%0d]", tag, k),   {31'd0, txO[k]},   32'd1);
            checkOutput($sformatf("%sBusy[%0d]", tag, k), {31'd0, busyO[k]}, 32'd0);
            checkOutput($sformatf("%sRd[%0d]", tag, k),   {31'd0, rdEnO[k]}, 32'd0);
            checkOutput($sformatf("%sDone[%0d]", tag, k), {31'd0, doneO[k]}, 32'd0);
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < maxCycles && !reached; i++) begin
            @(negedge clk);
            #1;
            if (phase[0] == -1 && phase[1] == -1 && phase[2] == -1 && (!enable || (&fifoEmpty)))
                reached = 1'b1;
        end
        checkOutput("idleReached", {31'd0, reached}, 32'd1);
        if (reached) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("busyAtIdle[%0d]", k), {31'd0, busyO[k]}, 32'd0);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        enable = 1'b0;
        sawRdEn = '0;
        inFrame = '0;

        // Asynchronous reset before any clock edge, then held.
        #2 rst = 1'b1;
        #1 checkResetState("rstAsync");
        repeat (5) @(negedge clk);
        checkResetState("rstHold");
        rst = 1'b0;

        // Single word.
        pushAll(10'h2A5);
        takeSnap();
        applyStimulus(1'b1, 1);
        waitIdle(200);
        checkPops("singlePops", 1);

        // Back-to-back words.
        pushAll(10'h001);
        pushAll(10'h3FF);
        pushAll(10'h155);
        takeSnap();
        applyStimulus(1'b1, 1);
        waitIdle(400);
        checkPops("b2bPops", 3);

        // Parity word.
        pushAll(10'h007);
        takeSnap();
        applyStimulus(1'b1, 1);
        waitIdle(200);
        checkPops("parityPops", 1);

        // Empty FIFO with enable high.
        takeSnap();
        applyStimulus(1'b1, 50);
        checkPops("emptyPops", 0);

        // Enable dropped mid-frame: frame completes, the queued word stays.
        pushAll(10'h0F0);
        pushAll(10'h155);
        takeSnap();
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 1);
        waitIdle(200);
        checkPops("gatedPops", 1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("gatedLeft[%0d]", k), {31'd0, fifoEmpty[k]}, 32'd0);
        end

        // Reset during the third data bit.
        pushAll(10'h2C3);
        takeSnap();
        applyStimulus(1'b1, 16);
        rst = 1'b1;
        #1 checkResetState("rstMid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("popAfterRst[%0d]", k), {31'd0, rdEnO[k]}, 32'd1);
        end
        waitIdle(200);
        checkPops("rstPops", 2);

        // Randomized traffic with enable toggling.
        enable = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) pushWord(int'($urandom_range(0, 2)), 10'($urandom));
            if ($urandom_range(0, 15) == 0) enable = ~enable;
        end
        enable = 1'b1;
        waitIdle(5000);
        checkOutput("drained", {29'd0, fifoEmpty}, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
